scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, giving the width of the per-channel dwell count.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a scan; acted on only in IDLE.
REQ-005 SHALL have port stop, input, 1 bit: abort an active scan.
REQ-006 SHALL have port dwell, input, DWELL_W bits: each channel is held for dwell+1 cycles.
REQ-007 SHALL have port mask, input, 8 bits: per-channel scan enable. Present only with SCAN_MASK_EN.
REQ-008 SHALL have port X, output, 3 bits: channel select; drives the 3-to-8 decoder X input.
REQ-009 SHALL have port En, output, 1 bit: decoder enable; high only while a channel is being dwelt on.
REQ-010 SHALL have port busy, output, 1 bit: high in SCAN and DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on normal scan completion.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 All outputs SHALL be registered.
REQ-014 In IDLE, start=1 SHALL load the following at that clock edge:
- dwell into a shadow register;
- mask into a shadow register;
- X = lowest enabled channel;
- count = 0;
- En = 1;
- state = SCAN.
  Start at edge n gives En=1 visible from cycle n+1.
REQ-015 If no channel is enabled at start, the FSM SHALL go IDLE->DONE with En held 0.
REQ-016 In SCAN, count SHALL increment each cycle while count != shadow dwell.
REQ-017 In SCAN with count == shadow dwell:
- X SHALL advance to the next higher enabled channel and count SHALL clear to 0;
- if no higher enabled channel exists, state SHALL become DONE and En SHALL become 0.
REQ-018 Channels SHALL be visited in ascending order only, with no wrap-around from 7 to 0. Disabled channels SHALL be skipped with zero idle cycles between enabled channels.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. start in DONE SHALL be ignored.
REQ-020 stop=1 in SCAN SHALL do all of the following at the next edge:
- state = IDLE;
- En = 0;
- X = 0;
- no done pulse.
REQ-021 stop SHALL be ignored in IDLE and DONE. If start and stop are both 1 in IDLE, start SHALL take effect.
REQ-022 start in SCAN SHALL be ignored. Changes on dwell and mask during a scan SHALL have no effect, because the shadow copies are used.
REQ-023 X SHALL return to 0 whenever En falls.

Reset
REQ-024 rst=1 SHALL force the following at the next edge, regardless of state:
- state = IDLE;
- X = 0, En = 0, busy = 0, done = 0;
- count = 0 and shadow registers = 0.
REQ-025 rst SHALL have priority over start and stop.

Configuration
REQ-026 Macro SCAN_MASK_EN:
- defined: the mask port exists and masked-out channels are skipped;
- undefined: the mask port is absent and the mask is treated as 8'hFF, so all 8 channels are scanned and REQ-015 cannot occur.

Structure
REQ-027 Package scan_pkg SHALL hold the following:
- state typedef (IDLE/SCAN/DONE);
- NUM_CH = 8;
- SEL_W = 3.
REQ-028 Sub-module next_ch_find SHALL be combinational. It takes the current X and the shadow mask, and returns found plus the next higher enabled channel. It is also used with a "from -1" input to find the first channel.

Verification
REQ-029 dwell=2, mask=8'hFF, start at cycle 0:
- X = 0..7, each for 3 cycles with En=1, over cycles 1-24;
- done=1 at cycle 25;
- busy=0 from cycle 26.
REQ-030 dwell=0, mask=8'b1010_0100, start at cycle 0:
- X = 2, 5, 7 in cycles 1, 2, 3;
- En=1 in cycles 1-3;
- done at cycle 4.
REQ-031 dwell=4, mask=8'hFF, stop asserted while X=3:
- En=0 and X=0 the next cycle;
- done never pulses;
- busy=0.
REQ-032 mask=8'h00, start at cycle 0:
- En stays 0;
- done=1 at cycle 1;
- IDLE at cycle 2.
REQ-033 rst asserted while X=5 and En=1: all outputs are 0 the next cycle; a new start then restarts from the lowest enabled channel.
REQ-034 start pulsed during SCAN and during DONE is ignored, and dwell changed mid-scan is ignored: scan timing is unchanged versus REQ-029.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/next_ch_find.sv
// Combinational search for the next enabled channel strictly above cur_i.
// With from_neg1_i set the search starts below channel 0, which yields the
// lowest enabled channel (used when a scan is launched).
module next_ch_find
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              from_neg1_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic              found_o,
  output logic [SEL_W-1:0]  next_o
);

  // Priority scan from channel 0 upward; the first hit above cur_i wins.
  always_comb begin
    found_o = 1'b0;
    next_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found_o && mask_i[i] && (from_neg1_i || (i > int'(cur_i)))) begin
        found_o = 1'b1;
        next_o  = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 3-to-8 decoder (X select, En enable).
// Each enabled channel is held for dwell+1 cycles in ascending order; a
// one-cycle done pulse marks normal completion, stop aborts silently.
// Optional feature macro SCAN_MASK_EN: when defined, the mask port exists
// and masked-out channels are skipped; otherwise all 8 channels are scanned.
// Handshake: start is a level sampled only in IDLE, stop only in SCAN;
// there is no ready/ack, busy reports SCAN or DONE and all outputs are
// registered. dbg_state_o exposes the FSM state for observation.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0]  mask,
`endif
  output logic [SEL_W-1:0]   X,
  output logic               En,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state_o
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   x_q, x_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
  logic [NUM_CH-1:0]  mask_sh_q, mask_sh_d;
  logic [NUM_CH-1:0]  mask_in;

  logic               first_found;
  logic [SEL_W-1:0]   first_ch;
  logic               next_found;
  logic [SEL_W-1:0]   next_ch;

`ifdef SCAN_MASK_EN
  assign mask_in = mask;
`else
  assign mask_in = {NUM_CH{1'b1}};
`endif

  // The first channel is searched on the live mask, since the shadow is
  // loaded on the same edge that starts the scan.
  next_ch_find u_first (
    .cur_i       ('0),
    .from_neg1_i (1'b1),
    .mask_i      (mask_in),
    .found_o     (first_found),
    .next_o      (first_ch)
  );

  next_ch_find u_next (
    .cur_i       (x_q),
    .from_neg1_i (1'b0),
    .mask_i      (mask_sh_q),
    .found_o     (next_found),
    .next_o      (next_ch)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    dwell_sh_d = dwell_sh_q;
    mask_sh_d  = mask_sh_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dwell_sh_d = dwell;
          mask_sh_d  = mask_in;
          cnt_d      = '0;
          busy_d     = 1'b1;
          if (first_found) begin
            x_d     = first_ch;
            en_d    = 1'b1;
            state_d = SCAN;
          end else begin
            x_d     = '0;
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          x_d     = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != dwell_sh_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else if (next_found) begin
          x_d   = next_ch;
          cnt_d = '0;
        end else begin
          state_d = DONE;
          x_d     = '0;
          en_d    = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      dwell_sh_q <= '0;
      mask_sh_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      dwell_sh_q <= dwell_sh_d;
      mask_sh_q  <= mask_sh_d;
    end
  end

  assign X           = x_q;
  assign En          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed testbench for scan_sequencer. Expected per-cycle traces are
// built from hand-derived scan rules into exp_q and compared cycle by cycle.
// Mask-dependent cases run only when SCAN_MASK_EN is defined.
module tb_scan_sequencer;
  import scan_pkg::*;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_MASK_EN
  logic [7:0]         mask;
`endif
  logic [2:0]         X;
  logic               En;
  logic               busy;
  logic               done;
  state_t             dbg_state;

  int n_checks;
  int n_fail;

  // {busy, done, En, X}
  logic [5:0] exp_q[$];

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dwell       (dwell),
`ifdef SCAN_MASK_EN
    .mask        (mask),
`endif
    .X           (X),
    .En          (En),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers: advance one edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected trace of a full scan: each enabled channel for d+1 cycles,
  // then one DONE cycle, then idle.
  task automatic push_scan(input int d, input logic [7:0] m);
    for (int ch = 0; ch < 8; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k <= d; k++) exp_q.push_back({1'b1, 1'b0, 1'b1, 3'(ch)});
      end
    end
    exp_q.push_back(6'b11_0_000);
    exp_q.push_back(6'b00_0_000);
  endtask

  // Consumes exp_q one cycle at a time. With perturb set, it disturbs the
  // scan with inputs that must be ignored: dwell change, start in SCAN,
  // and start plus stop during DONE.
  task automatic run_trace(input string tag, input bit perturb);
    int c;
    logic [5:0] e;
    c = 0;
    while (exp_q.size() > 0) begin
      tick();
      c++;
      if (c == 1) start = 1'b0;
      if (perturb && c == 6) start = 1'b0;
      if (perturb && c == 26) begin
        start = 1'b0;
        stop  = 1'b0;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s_c%0d", tag, c), {26'd0, busy, done, En, X}, {26'd0, e});
      if (perturb) begin
        if (c == 3) dwell = 8'd7;
        if (c == 5) start = 1'b1;
        if (c == 25) begin
          start = 1'b1;
          stop  = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int dcount;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dwell = '0;
`ifdef SCAN_MASK_EN
    mask  = 8'hFF;
`endif
    tick();
    tick();
    chk("rst_X", 32'(X), 32'd0);
    chk("rst_En", 32'(En), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // Full scan, dwell=2: X 0..7 for 3 cycles each, done at cycle 25.
    dwell = 8'd2;
    start = 1'b1;
    push_scan(2, 8'hFF);
    run_trace("scan_d2", 1'b0);
    chk("scan_d2_state", 32'(dbg_state), 32'(IDLE));

    // Same scan with ignored start/dwell/stop disturbances.
    dwell = 8'd2;
    start = 1'b1;
    push_scan(2, 8'hFF);
    run_trace("ignore", 1'b1);
    tick();
    chk("ignore_idle_En", 32'(En), 32'd0);
    chk("ignore_idle_state", 32'(dbg_state), 32'(IDLE));

    // Stop while X=3 (dwell=4: X=3 occupies cycles 16-20).
    dwell = 8'd4;
    start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      start = 1'b0;
    end
    chk("stop_pre_X", 32'(X), 32'd3);
    chk("stop_pre_En", 32'(En), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_X", 32'(X), 32'd0);
    chk("stop_En", 32'(En), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_state", 32'(dbg_state), 32'(IDLE));
    dcount = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    chk("stop_no_done", 32'(dcount), 32'd0);

    // start and stop together in IDLE: start wins.
    dwell = 8'd0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_En", 32'(En), 32'd1);
    chk("startstop_X", 32'(X), 32'd0);
    chk("startstop_busy", 32'(busy), 32'd1);

    // Reset mid-scan at X=5 (dwell=0: X=5 at cycle 6).
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_pre_X", 32'(X), 32'd5);
    chk("rstmid_pre_En", 32'(En), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk("rstmid_out", {28'd0, busy, done, En, 1'b0} | 32'(X), 32'd0);
    chk("rstmid_state", 32'(dbg_state), 32'(IDLE));
    rst  = 1'b0;
    stop = 1'b0;
`ifdef SCAN_MASK_EN
    mask = 8'b1010_0100;
`endif
    tick();
    start = 1'b0;
`ifdef SCAN_MASK_EN
    chk("restart_X", 32'(X), 32'd2);
`else
    chk("restart_X", 32'(X), 32'd0);
`endif
    chk("restart_En", 32'(En), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

`ifdef SCAN_MASK_EN
    // Sparse mask, dwell=0: X=2,5,7 in cycles 1-3, done at cycle 4.
    dwell = 8'd0;
    mask  = 8'b1010_0100;
    start = 1'b1;
    push_scan(0, 8'b1010_0100);
    run_trace("sparse", 1'b0);

    // Empty mask: En stays 0, done at cycle 1, IDLE at cycle 2.
    mask  = 8'h00;
    start = 1'b1;
    push_scan(0, 8'h00);
    run_trace("empty", 1'b0);
    chk("empty_state", 32'(dbg_state), 32'(IDLE));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
